program_fetch_det: RTL and testbench

PROGRAM_FETCH_DET -- requirements
Module: program_fetch_det

---
 rtl/det_pkg.sv | 30 +++
 rtl/det_mul4.sv | 60 ++++++
 rtl/program_fetch_det.sv | 165 ++++++++++++++++
 tb/tb_program_fetch_det.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/det_pkg.sv
// det_pkg -- shared definitions for program_fetch_det and det_mul4.
//   state_t    : controller FSM states
//   *_LSB      : bit positions of the four nibbles inside a 16-bit ROM word
//   RESULT_W   : width of the signed ad-bc result (range -225..+225)
//   get_nib()  : extract one 4-bit field from a ROM word
package det_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    MUL_AD,
    MUL_BC,
    SUB,
    OUT,
    DONE
  } state_t;

  localparam int NIB_W    = 4;
  localparam int A_LSB    = 0;
  localparam int C_LSB    = 4;
  localparam int D_LSB    = 8;
  localparam int B_LSB    = 12;
  localparam int PROD_W   = 8;
  localparam int RESULT_W = 9;

  function automatic logic [NIB_W-1:0] get_nib(input logic [15:0] w, input int lsb);
    return w[lsb +: NIB_W];
  endfunction

endpackage

// File: rtl/det_mul4.sv
// det_mul4 -- 4x4 unsigned shift-add multiplier, one partial product per cycle.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   start         : 1-cycle pulse; operands are captured and bit 0 is accumulated
//   op_a, op_b    : 4-bit unsigned operands (sampled only when start is high)
//   product       : 8-bit unsigned product, valid while done is high
//   done          : high in the 4th cycle after start (the cycle after the pulse
//                   counts as cycle 2), i.e. the multiply occupies exactly 4 cycles
module det_mul4
  import det_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NIB_W-1:0]    op_a,
  input  logic [NIB_W-1:0]    op_b,
  output logic [PROD_W-1:0]   product,
  output logic                done
);

  logic [NIB_W-1:0]  a_reg;
  logic [NIB_W-1:0]  b_reg;
  logic [PROD_W-1:0] acc_reg;
  logic [1:0]        cnt_reg;
  logic              active_reg;
  logic [PROD_W-1:0] step_term;

  // Partial product for the multiplier bit selected by cnt_reg.
  always_comb begin
    step_term = ({{(PROD_W-NIB_W){1'b0}}, a_reg} & {PROD_W{b_reg[cnt_reg]}}) << cnt_reg;
  end

  // The last partial product is added combinationally so the full product is
  // available in the 4th cycle rather than one cycle later.
  assign product = acc_reg + step_term;
  assign done    = active_reg && (cnt_reg == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg      <= '0;
      b_reg      <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      active_reg <= 1'b0;
    end else if (start) begin
      a_reg      <= op_a;
      b_reg      <= op_b;
      acc_reg    <= {{(PROD_W-NIB_W){1'b0}}, op_a & {NIB_W{op_b[0]}}};
      cnt_reg    <= 2'd1;
      active_reg <= 1'b1;
    end else if (active_reg) begin
      acc_reg <= product;
      cnt_reg <= cnt_reg + 2'd1;
      if (cnt_reg == 2'd3) begin
        active_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/program_fetch_det.sv
// program_fetch_det -- walks a 16-word program ROM and emits ad-bc per word.
// Each word is split into a=[3:0], c=[7:4], d=[11:8], b=[15:12]; the signed
// 9-bit result ad-bc is offered on a valid/ready port tagged with its address.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start           : begin a run from address 0 (ignored while busy)
//   Rom_addr_out    : address to the combinational program ROM (registered pc)
//   Rom_data_in     : ROM word for Rom_addr_out, same cycle
//   result          : signed ad-bc
//   result_addr     : ROM address that produced result
//   result_valid    : result offered; held until result_ready at a clock edge
//   result_ready    : consumer accepts result
//   busy            : state is not IDLE
//   done            : one-cycle pulse at the end of a run
// Parameter LAST_ADDR : last ROM address processed in a run.
// Optional macro DET_HALT_WORD_EN: a fetched word of 16'h0000 ends the run
// immediately without producing a result.
module program_fetch_det
  import det_pkg::*;
#(
  parameter logic [3:0] LAST_ADDR = 4'hF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [3:0]          Rom_addr_out,
  input  logic [15:0]         Rom_data_in,
  output logic [RESULT_W-1:0] result,
  output logic [3:0]          result_addr,
  output logic                result_valid,
  input  logic                result_ready,
  output logic                busy,
  output logic                done
);

  state_t              state_reg;
  logic [3:0]          pc_reg;
  logic [15:0]         word_reg;
  logic [PROD_W-1:0]   ad_reg;
  logic [PROD_W-1:0]   bc_reg;
  logic [RESULT_W-1:0] result_reg;
  logic [3:0]          result_addr_reg;
  logic                result_valid_reg;
  logic                busy_reg;
  logic                done_reg;
  logic                mul_start_reg;

  logic [NIB_W-1:0]    mul_op_a;
  logic [NIB_W-1:0]    mul_op_b;
  logic [PROD_W-1:0]   mul_product;
  logic                mul_done;

  // One multiplier is shared: operands a,d during MUL_AD and b,c during MUL_BC.
  always_comb begin
    mul_op_a = get_nib(word_reg, A_LSB);
    mul_op_b = get_nib(word_reg, D_LSB);
    if (state_reg == MUL_BC) begin
      mul_op_a = get_nib(word_reg, B_LSB);
      mul_op_b = get_nib(word_reg, C_LSB);
    end
  end

  det_mul4 u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start_reg),
    .op_a    (mul_op_a),
    .op_b    (mul_op_b),
    .product (mul_product),
    .done    (mul_done)
  );

  // mul_start_reg is raised on entry to each multiply state so the multiplier
  // starts in the first cycle of MUL_AD / MUL_BC; this fixes the latency at
  // FETCH(1) + MUL_AD(4) + MUL_BC(4) + SUB(1) before result_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      pc_reg           <= '0;
      word_reg         <= '0;
      ad_reg           <= '0;
      bc_reg           <= '0;
      result_reg       <= '0;
      result_addr_reg  <= '0;
      result_valid_reg <= 1'b0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      mul_start_reg    <= 1'b0;
    end else begin
      mul_start_reg <= 1'b0;
      done_reg      <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            pc_reg    <= '0;
            busy_reg  <= 1'b1;
            state_reg <= FETCH;
          end
        end
        FETCH: begin
          word_reg <= Rom_data_in;
`ifdef DET_HALT_WORD_EN
          if (Rom_data_in == 16'h0000) begin
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else begin
            mul_start_reg <= 1'b1;
            state_reg     <= MUL_AD;
          end
`else
          mul_start_reg <= 1'b1;
          state_reg     <= MUL_AD;
`endif
        end
        MUL_AD: begin
          if (mul_done) begin
            ad_reg        <= mul_product;
            mul_start_reg <= 1'b1;
            state_reg     <= MUL_BC;
          end
        end
        MUL_BC: begin
          if (mul_done) begin
            bc_reg    <= mul_product;
            state_reg <= SUB;
          end
        end
        SUB: begin
          result_reg       <= {1'b0, ad_reg} - {1'b0, bc_reg};
          result_addr_reg  <= pc_reg;
          result_valid_reg <= 1'b1;
          state_reg        <= OUT;
        end
        OUT: begin
          if (result_ready) begin
            result_valid_reg <= 1'b0;
            if (pc_reg == LAST_ADDR) begin
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end else begin
              pc_reg    <= pc_reg + 4'd1;
              state_reg <= FETCH;
            end
          end
        end
        DONE: begin
          pc_reg    <= '0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign Rom_addr_out = pc_reg;
  assign result       = result_reg;
  assign result_addr  = result_addr_reg;
  assign result_valid = result_valid_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;

endmodule

// File: tb/tb_program_fetch_det.sv
module tb_program_fetch_det;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  Rom_addr_out;
  logic [15:0] Rom_data_in;
  logic [8:0]  result;
  logic [3:0]  result_addr;
  logic        result_valid;
  logic        result_ready = 1'b0;
  logic        busy;
  logic        done;

  logic [15:0] rom [16];
  assign Rom_data_in = rom[Rom_addr_out];

  program_fetch_det #(.LAST_ADDR(4'h3)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .Rom_addr_out (Rom_addr_out),
    .Rom_data_in  (Rom_data_in),
    .result       (result),
    .result_addr  (result_addr),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: a*d - b*c in plain integer arithmetic, truncated to 9 bits.
  function automatic logic [8:0] model(input logic [15:0] w);
    int a, b, c, d, v;
    logic [31:0] vv;
    a = int'(w[3:0]);
    c = int'(w[7:4]);
    d = int'(w[11:8]);
    b = int'(w[15:12]);
    v = a * d - b * c;
    vv = v;
    return vv[8:0];
  endfunction

  // Transfers observed on the result port (valid && ready sampled mid-cycle).
  logic [8:0] got_res [$];
  logic [3:0] got_addr [$];
  bit         prev_hold = 1'b0;
  logic [8:0] prev_res;
  logic [3:0] prev_addr;

  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", result_valid, 1);
        check("hold_result", result, prev_res);
        check("hold_addr", result_addr, prev_addr);
      end
      prev_hold = result_valid && !result_ready;
      prev_res  = result;
      prev_addr = result_addr;
      if (result_valid && result_ready) begin
        got_res.push_back(result);
        got_addr.push_back(result_addr);
        $display("xfer addr=%0d result=%0d (0x%03h)", result_addr, $signed(result), result);
      end
    end
  end

  bit rdy_rand = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rdy_rand) result_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] word;
    logic [8:0]  exp;
  } vec_t;

  vec_t        tbl [8];
  logic [15:0] prog_w [4];
  logic [8:0]  prog_e [4];

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_prog(input int n_exp, input bit rand_rdy, input bit chk_lat, input bit poke_start);
    int  first_valid;
    bit  seen_done;
    for (int i = 0; i < 4; i++) rom[i] = prog_w[i];
    got_res.delete();
    got_addr.delete();
    rdy_rand = rand_rdy;
    if (!rand_rdy) result_ready = 1'b1;
    pulse_start();
    first_valid = -1;
    seen_done = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (first_valid < 0 && result_valid) first_valid = k;
      if (k == 5) check("busy_run", busy, 1);
      start = poke_start && (k == 25 || k == 40);
      if (done) begin
        seen_done = 1'b1;
        break;
      end
    end
    start = 1'b0;
    check("done_seen", seen_done, 1);
    if (chk_lat) check("latency", first_valid, 10);
    @(negedge clk);
    check("done_width", done, 0);
    check("busy_idle", busy, 0);
    rdy_rand = 1'b0;
    check("n_results", got_res.size(), n_exp);
    for (int i = 0; i < n_exp; i++) begin
      if (i < got_res.size()) begin
        check("result", got_res[i], prog_e[i]);
        check("result_addr", got_addr[i], i);
      end
    end
  endtask

  initial begin
    bit seen;
    for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
    tbl[0] = '{16'h1234, 9'h005};
    tbl[1] = '{16'h2138, 9'h002};
    tbl[2] = '{16'h1256, 9'h007};
    tbl[3] = '{16'h7757, 9'h00E};
    tbl[4] = '{16'hF0F0, 9'h11F};
    tbl[5] = '{16'h0F0F, 9'h0E1};
    tbl[6] = '{16'h1F1F, 9'h0E0};
    tbl[7] = '{16'hF1F1, 9'h120};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_addr", Rom_addr_out, 0);
    check("rst_result", result, 0);
    check("rst_raddr", result_addr, 0);
    check("rst_valid", result_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy", busy, 0);

    // Table-driven programs, ready tied high
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 4; i++) begin
        prog_w[i] = tbl[p*4+i].word;
        prog_e[i] = tbl[p*4+i].exp;
      end
      run_prog(4, 1'b0, p == 0, 1'b0);
    end

    // Randomized programs with random ready and stray start pulses
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 4; i++) begin
        prog_w[i] = 16'($urandom);
        if (prog_w[i] == 16'h0000) prog_w[i] = 16'h0001;
        prog_e[i] = model(prog_w[i]);
      end
      run_prog(4, 1'b1, 1'b0, p[0]);
    end

    // Ready held low for 20 cycles in OUT
    prog_w[0] = 16'h7757; prog_w[1] = 16'h1234; prog_w[2] = 16'hF0F0; prog_w[3] = 16'h0F0F;
    for (int i = 0; i < 4; i++) begin
      rom[i] = prog_w[i];
      prog_e[i] = model(prog_w[i]);
    end
    got_res.delete();
    got_addr.delete();
    rdy_rand = 1'b0;
    result_ready = 1'b0;
    pulse_start();
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (result_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("hold_valid_seen", seen, 1);
    repeat (20) @(negedge clk);
    check("hold_no_xfer", got_res.size(), 0);
    check("hold_val_20", result, prog_e[0]);
    @(posedge clk);
    #1 result_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("hold_one_xfer", got_res.size(), 1);
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("hold_done", seen, 1);
    check("hold_total", got_res.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_res.size()) begin
        check("hold_res", got_res[i], prog_e[i]);
        check("hold_addr", got_addr[i], i);
      end
    end

    // Reset during MUL_BC of the second word
    for (int i = 0; i < 4; i++) rom[i] = tbl[i].word;
    got_res.delete();
    got_addr.delete();
    result_ready = 1'b1;
    pulse_start();
    repeat (18) @(negedge clk);
    check("pre_rst_addr", Rom_addr_out, 1);
    check("pre_rst_busy", busy, 1);
    #1 rst = 1'b1;
    #1;
    check("arst_addr", Rom_addr_out, 0);
    check("arst_result", result, 0);
    check("arst_raddr", result_addr, 0);
    check("arst_valid", result_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    got_res.delete();
    got_addr.delete();
    repeat (30) @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_valid", result_valid, 0);
    check("post_rst_xfers", got_res.size(), 0);
    for (int i = 0; i < 4; i++) begin
      prog_w[i] = tbl[i].word;
      prog_e[i] = tbl[i].exp;
    end
    run_prog(4, 1'b0, 1'b1, 1'b0);

    // Zero word at address 2
    prog_w[0] = 16'h1234; prog_w[1] = 16'h2138; prog_w[2] = 16'h0000; prog_w[3] = 16'h7757;
    for (int i = 0; i < 4; i++) prog_e[i] = model(prog_w[i]);
`ifdef DET_HALT_WORD_EN
    run_prog(2, 1'b0, 1'b0, 1'b0);
`else
    run_prog(4, 1'b0, 1'b0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
